// File: rtl/ex_muldiv_unit_if.sv
// ex_muldiv_unit_if: EX-stage <-> multiply/divide unit connection.
//   master : pipeline side, drives the M-ext request and observes stall/done/result
//   slave  : multiply/divide unit
// Signals:
//   E_md_start  request valid (level, held while md_stall=1)
//   E_md_op     funct3 of the M-extension op
//   E_src_a/b   forwarded rs1/rs2 operands
//   E_rd        destination register
//   md_stall    freeze request to the hazard unit
//   md_busy     an op is in flight
//   md_done     one-cycle result-valid pulse
//   md_result   result, valid while md_done=1
//   md_rd       destination register of the completed op
interface ex_muldiv_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             E_md_start;
    logic [2:0]       E_md_op;
    logic [WIDTH-1:0] E_src_a;
    logic [WIDTH-1:0] E_src_b;
    logic [4:0]       E_rd;
    logic             md_stall;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_result;
    logic [4:0]       md_rd;

    modport master (
        output E_md_start, E_md_op, E_src_a, E_src_b, E_rd,
        input  md_stall, md_busy, md_done, md_result, md_rd
    );

    modport slave (
        input  E_md_start, E_md_op, E_src_a, E_src_b, E_rd,
        output md_stall, md_busy, md_done, md_result, md_rd
    );
endinterface

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M multiply/divide unit for the EX stage.
// Magnitudes are processed one bit per cycle (shift-add multiply, restoring
// divide), then sign-corrected in a single fix-up cycle.
// Ports:
//   clk    rising-edge clock
//   rst    synchronous active-high reset
//   flush  abort any in-flight op (branch/jump redirect)
//   md     slave side of ex_muldiv_unit_if (request, stall, done, result, rd)
module ex_muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    ex_muldiv_unit_if.slave     md
);

    localparam int unsigned CntW = $clog2(WIDTH);

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [2:0]           op_q;
    logic [4:0]           rd_q;
    logic [WIDTH-1:0]     opnd_q;     // multiplicand (mul) or divisor (div) magnitude
    logic [2*WIDTH-1:0]   acc_q;      // mul: {partial, multiplier}; div: {remainder, quotient}
    logic [CntW-1:0]      cnt_q;
    logic                 neg_q;      // negate product / quotient
    logic                 neg_a_q;    // dividend was negative: remainder takes its sign
    logic [WIDTH-1:0]     result_q;
    logic [4:0]           rd_out_q;

    // Operand decode at accept
    logic             is_div, a_signed, b_signed, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag, special_res;
    logic             b_zero, ovf, special, accept;

    always_comb begin
        is_div   = md.E_md_op[2];
        a_signed = md.E_md_op inside {3'd1, 3'd2, 3'd4, 3'd6};
        b_signed = md.E_md_op inside {3'd1, 3'd4, 3'd6};
        a_neg    = a_signed & md.E_src_a[WIDTH-1];
        b_neg    = b_signed & md.E_src_b[WIDTH-1];
        a_mag    = a_neg ? -md.E_src_a : md.E_src_a;
        b_mag    = b_neg ? -md.E_src_b : md.E_src_b;
        b_zero   = is_div & (md.E_src_b == '0);
        ovf      = (md.E_md_op == 3'd4 || md.E_md_op == 3'd6)
                 & (md.E_src_a == {1'b1, {(WIDTH-1){1'b0}}})
                 & (md.E_src_b == '1);
        special  = b_zero | ovf;
        // op[1] distinguishes REM/REMU from DIV/DIVU
        special_res = '0;
        if (b_zero) begin
            special_res = md.E_md_op[1] ? md.E_src_a : '1;
        end else if (ovf) begin
            special_res = md.E_md_op[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
        end
        accept = (state_q == StIdle) & md.E_md_start & ~flush;
    end

    // One iteration step and the final sign fix-up
    logic [WIDTH:0]     mul_sum, div_r;
    logic [WIDTH-1:0]   div_diff, quo, rem, fix_res;
    logic               div_ge;
    logic [2*WIDTH-1:0] mul_next, div_next, prod;

    always_comb begin
        mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, opnd_q};
        mul_next = acc_q[0] ? {mul_sum, acc_q[WIDTH-1:1]} : {1'b0, acc_q[2*WIDTH-1:1]};
        div_r    = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
        div_ge   = div_r >= {1'b0, opnd_q};
        // When div_ge the difference is below the divisor, so the low bits suffice
        div_diff = div_r[WIDTH-1:0] - opnd_q;
        div_next = {(div_ge ? div_diff : div_r[WIDTH-1:0]), acc_q[WIDTH-2:0], div_ge};

        prod = neg_q ? -acc_q : acc_q;
        quo  = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem  = neg_a_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
        unique case (op_q)
            3'd0:                   fix_res = prod[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:       fix_res = prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:             fix_res = quo;
            default:                fix_res = rem;
        endcase
    end

    // FSM: state register
    always_ff @(posedge clk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (md.E_md_start) state_d = special ? StDone : StCalc;
            StCalc: if (cnt_q == CntW'(WIDTH - 1)) state_d = StFix;
            StFix:  state_d = StDone;
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (flush) state_d = StIdle;
    end

    // FSM: outputs
    always_comb begin
        md.md_done   = (state_q == StDone);
        md.md_busy   = (state_q != StIdle);
        md.md_stall  = md.E_md_start & ~md.md_done;
        md.md_result = result_q;
        md.md_rd     = rd_out_q;
    end

    // Datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            rd_q     <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            neg_a_q  <= 1'b0;
            result_q <= '0;
            rd_out_q <= '0;
        end else if (accept) begin
            op_q    <= md.E_md_op;
            rd_q    <= md.E_rd;
            cnt_q   <= '0;
            neg_q   <= a_neg ^ b_neg;
            neg_a_q <= a_neg;
            if (is_div) begin
                opnd_q <= b_mag;
                acc_q  <= {{WIDTH{1'b0}}, a_mag};
            end else begin
                opnd_q <= a_mag;
                acc_q  <= {{WIDTH{1'b0}}, b_mag};
            end
            if (special) begin
                result_q <= special_res;
                rd_out_q <= md.E_rd;
            end
        end else if (!flush && state_q == StCalc) begin
            acc_q <= op_q[2] ? div_next : mul_next;
            cnt_q <= cnt_q + 1'b1;
        end else if (!flush && state_q == StFix) begin
            result_q <= fix_res;
            rd_out_q <= rd_q;
        end
    end

endmodule
